// File: rtl/dual_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// dual_issue_queue_pkg
// Purpose : Shared CPU constants used by the dual-issue instruction queue and
//           its bus interface: instruction word width and issue width.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package dual_issue_queue_pkg;

    // Width of one fetched instruction word.
    localparam int INSTR_W = 32;

    // Maximum number of instructions issued per cycle.
    localparam int ISSUE_W = 2;

    // Bits needed to encode an issue count of 0..ISSUE_W.
    localparam int ICNT_W  = $clog2(ISSUE_W + 1);

endpackage

// File: rtl/dual_issue_queue_if.sv
// -----------------------------------------------------------------------------
// dual_issue_queue_if
// Purpose : Bundles the fetch-side handshake, the RAW detector hookup and the
//           issue-side handshake of the dual-issue queue.
// Signals :
//   flush               parent -> queue  discard all queued instructions
//   in_valid, in_instr  parent -> queue  fetch offer
//   in_ready            queue -> parent  push accepted this cycle
//   i0, i1              queue -> parent  two oldest entries (to RAW detector)
//   has_RAW_dependence  parent -> queue  detector verdict for (i0, i1)
//   issue_ready         parent -> queue  downstream accepts up to two
//   issue_count         queue -> parent  instructions issued this cycle
//   issue0_instr/1      queue -> parent  issued instruction words
// Modports: slave = the queue, master = the parent / testbench.
// -----------------------------------------------------------------------------
interface dual_issue_queue_if;
    import dual_issue_queue_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic [INSTR_W-1:0]   in_instr;
    logic                 in_ready;
    logic [INSTR_W-1:0]   i0;
    logic [INSTR_W-1:0]   i1;
    logic                 has_RAW_dependence;
    logic                 issue_ready;
    logic [ICNT_W-1:0]    issue_count;
    logic [INSTR_W-1:0]   issue0_instr;
    logic [INSTR_W-1:0]   issue1_instr;

    modport slave (
        input  flush, in_valid, in_instr, has_RAW_dependence, issue_ready,
        output in_ready, i0, i1, issue_count, issue0_instr, issue1_instr
    );

    modport master (
        output flush, in_valid, in_instr, has_RAW_dependence, issue_ready,
        input  in_ready, i0, i1, issue_count, issue0_instr, issue1_instr
    );

endinterface

// File: rtl/dual_issue_queue.sv
// -----------------------------------------------------------------------------
// dual_issue_queue
// Purpose : Circular instruction queue feeding a dual-issue stage. Presents
//           the two oldest entries to an external RAW detector and issues
//           0, 1 or 2 instructions per cycle with zero latency from head.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous, active-low reset (clears pointers and occupancy)
//   bus   dual_issue_queue_if.slave (fetch, detector and issue signals)
// Parameter:
//   DEPTH number of entries, power of two, >= 2
// -----------------------------------------------------------------------------
module dual_issue_queue
    import dual_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    dual_issue_queue_if.slave   bus
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dual_issue_queue: DEPTH must be a power of two >= 2");
    end

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;

    logic [PTR_W:0]     w_cnt;
    logic [PTR_W-1:0]   w_head1;
    logic               w_ready;
    logic               w_push;
    logic [ICNT_W-1:0]  w_icnt;
    logic [INSTR_W-1:0] w_i0;
    logic [INSTR_W-1:0] w_i1;

    always_comb begin
        // While reset is held the queue looks empty: nothing is shown,
        // nothing issues, and the fetch side sees a ready queue.
        w_cnt   = rst ? r_count : '0;
        w_head1 = r_head + PTR_W'(1);
        w_ready = (w_cnt < CNT_FULL);
        w_push  = bus.in_valid && w_ready && !bus.flush && rst;

        w_i0 = (w_cnt != '0)     ? r_mem[r_head]  : '0;
        w_i1 = (w_cnt > CNT_ONE) ? r_mem[w_head1] : '0;

        // Dual issue only when two entries exist and the detector clears them.
        w_icnt = '0;
        if (!bus.issue_ready || bus.flush || (w_cnt == '0)) begin
            w_icnt = '0;
        end else if ((w_cnt == CNT_ONE) || bus.has_RAW_dependence) begin
            w_icnt = ICNT_W'(1);
        end else begin
            w_icnt = ICNT_W'(2);
        end
    end

    // Pointer/occupancy state; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            r_head  <= r_head + PTR_W'(w_icnt);
            r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_icnt);
        end
    end

    // Entry storage carries no reset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= bus.in_instr;
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.i0           = w_i0;
    assign bus.i1           = w_i1;
    assign bus.issue_count  = w_icnt;
    assign bus.issue0_instr = w_i0;
    assign bus.issue1_instr = w_i1;

endmodule

// File: doc/dual_issue_queue.md
DUAL_ISSUE_QUEUE -- requirements
Module: dual_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of 32-bit instruction entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  discard all queued instructions.
REQ-005 in_valid  input  1  fetch offers in_instr.
REQ-006 in_instr  input  32  fetched instruction.
REQ-007 in_ready  output  1  queue accepts a push this cycle.
REQ-008 i0  output  32  oldest entry; drives the RAW detector's first instruction.
REQ-009 i1  output  32  second-oldest entry; drives the RAW detector's second instruction.
REQ-010 has_RAW_dependence  input  1  detector result for (i0, i1); valid in the same cycle, purely combinational.
REQ-011 issue_ready  input  1  downstream accepts up to two instructions this cycle.
REQ-012 issue_count  output  2  instructions issued this cycle: 0, 1 or 2.
REQ-013 issue0_instr  output  32  equals i0.
REQ-014 issue1_instr  output  32  equals i1; meaningful only when issue_count==2.

Function
REQ-015 Storage SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
REQ-016 in_ready SHALL be (count < DEPTH) and SHALL depend only on registered state, never on same-cycle pops.
REQ-017 A push occurs when in_valid && in_ready && !flush; in_instr is written at tail, and tail then increments.
REQ-018 i0 SHALL be entry[head] and i1 SHALL be entry[head+1 mod DEPTH]; when fewer entries are valid, the invalid outputs SHALL read 32'h0.
REQ-019 issue_count SHALL be 0 if !issue_ready, flush, or count==0.
REQ-020 Otherwise issue_count SHALL be 1 if count==1 or has_RAW_dependence==1.
REQ-021 Otherwise issue_count SHALL be 2.
REQ-022 A pop SHALL advance head by issue_count in the same cycle; issue latency is zero cycles from head occupancy.
REQ-023 A push and a pop in the same cycle SHALL both take effect; count_next = count + push - issue_count.
REQ-024 A push into an empty queue SHALL be visible on i0 the following cycle, never in the same cycle (no bypass).
REQ-025 With the queue full and issue_count>0, in_ready SHALL remain 0 that cycle; the freed slot is usable next cycle.
REQ-026 flush SHALL set head=tail=count=0 next cycle, take priority over push and pop, and force issue_count=0 in its cycle.
REQ-027 Entry contents need not be cleared by flush or reset; validity is derived solely from count.
REQ-028 Instruction order SHALL be strictly preserved; issue0 is always older than issue1.

Reset
REQ-029 When rst==0 at a rising edge, head, tail and count SHALL become 0.
REQ-030 During and directly after reset: in_ready=1, issue_count=0, i0=i1=32'h0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; any push or pop in that cycle is ignored.

Structure
REQ-032 The instruction word width (32) and the issue-width constant (2) SHALL live in the shared CPU package; DEPTH stays a module parameter.
REQ-033 The block SHALL NOT instantiate the RAW dependence detector; the parent connects i0/i1 to it and returns has_RAW_dependence. No sub-module is required.

Verification
REQ-034 Reset, then push A,B,C,D on consecutive cycles with issue_ready=0 -> count=4, in_ready=0 on the cycle after D, i0=A, i1=B.
REQ-035 Full queue (A..D), issue_ready=1, has_RAW_dependence=0 for two cycles -> issue_count=2 with (A,B), then 2 with (C,D), then count=0.
REQ-036 Queue holds A,B; issue_ready=1; has_RAW_dependence=1 -> issue_count=1 (A); next cycle i0=B, and with count==1, issue_count=1 regardless of has_RAW_dependence.
REQ-037 Steady push every cycle with alternating dependence over 3*DEPTH instructions -> output order matches input order across pointer wrap; no loss or duplication.
REQ-038 Three entries queued; flush=1 with in_valid=1 and issue_ready=1 -> issue_count=0 that cycle, count=0 next cycle, pushed word dropped.
REQ-039 Two entries queued; rst=0 for one cycle with in_valid=1 -> next cycle count=0, in_ready=1, issue_count=0.
